// File: rtl/nov2ph_seq.sv
// Burst sequencer driving the nov2ph phase clock: integrator reset, n programmable periods, flush, done pulse.
// Optional abort of RESET/RUN is compiled in with NOV2PH_SEQ_ABORT_EN.
module nov2ph_seq #(
    parameter int HALF_W     = 8,
    parameter int N_W        = 10,
    parameter int RST_CYC    = 4,
    parameter int SETTLE_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [HALF_W-1:0] half_per,
    input  logic [N_W-1:0]    n_per,
    output logic              phclk,
    output logic              int_rst,
    output logic              busy,
    output logic              done,
    output logic [N_W-1:0]    per_cnt
);

    localparam int MAX_CYC = (RST_CYC > SETTLE_CYC) ? RST_CYC : SETTLE_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_SETTLE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cyc_q, cyc_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
    logic [N_W-1:0]    nper_q, nper_d;
    logic [N_W-1:0]    per_cnt_q, per_cnt_d;
    logic              phclk_q, phclk_d;
    logic              int_rst_q, int_rst_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              abort_hit;

`ifdef NOV2PH_SEQ_ABORT_EN
    assign abort_hit = abort;
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign abort_hit    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        half_d     = half_q;
        half_cnt_d = half_cnt_q;
        nper_d     = nper_q;
        per_cnt_d  = per_cnt_q;
        phclk_d    = phclk_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    half_d    = (half_per == '0) ? HALF_W'(1) : half_per;
                    nper_d    = n_per;
                    per_cnt_d = '0;
                    cyc_d     = RST_LD;
                    state_d   = S_RESET;
                end
            end
            S_RESET: begin
                if (abort_hit) begin
                    cyc_d   = SETTLE_LD;
                    state_d = S_SETTLE;
                end else if (cyc_q == '0) begin
                    if (nper_q != '0) begin
                        half_cnt_d = '0;
                        phclk_d    = 1'b1;
                        state_d    = S_RUN;
                    end else begin
                        cyc_d   = SETTLE_LD;
                        state_d = S_SETTLE;
                    end
                end else begin
                    cyc_d = cyc_q - 1'b1;
                end
            end
            S_RUN: begin
                if (abort_hit) begin
                    cyc_d   = SETTLE_LD;
                    state_d = S_SETTLE;
                end else if (half_cnt_q == half_q - 1'b1) begin
                    half_cnt_d = '0;
                    if (phclk_q) begin
                        phclk_d = 1'b0;
                    end else begin
                        // last low cycle of the period: count it, saturating at n
                        if (per_cnt_q != nper_q) begin
                            per_cnt_d = per_cnt_q + 1'b1;
                        end
                        if (per_cnt_q + 1'b1 >= nper_q) begin
                            cyc_d   = SETTLE_LD;
                            state_d = S_SETTLE;
                        end else begin
                            phclk_d = 1'b1;
                        end
                    end
                end else begin
                    half_cnt_d = half_cnt_q + 1'b1;
                end
            end
            S_SETTLE: begin
                if (cyc_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cyc_d = cyc_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // phclk only ever leaves the flop high while RUN continues
        if (state_d != S_RUN) begin
            phclk_d = 1'b0;
        end
        int_rst_d = (state_d == S_RESET);
        busy_d    = (state_d == S_RESET) || (state_d == S_RUN) || (state_d == S_SETTLE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cyc_q      <= '0;
            half_q     <= '0;
            half_cnt_q <= '0;
            nper_q     <= '0;
            per_cnt_q  <= '0;
            phclk_q    <= 1'b0;
            int_rst_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            half_q     <= half_d;
            half_cnt_q <= half_cnt_d;
            nper_q     <= nper_d;
            per_cnt_q  <= per_cnt_d;
            phclk_q    <= phclk_d;
            int_rst_q  <= int_rst_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign phclk   = phclk_q;
    assign int_rst = int_rst_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign per_cnt = per_cnt_q;

endmodule

// File: tb/tb_nov2ph_seq.sv
// Directed bench for nov2ph_seq: each burst is traced cycle by cycle against closed-form timing.
module tb_nov2ph_seq;

    localparam int RST_C = 4;
    localparam int SET_C = 2;

    localparam int EV_NONE   = 0;
    localparam int EV_RST    = 1;
    localparam int EV_ABORT  = 2;
    localparam int EV_IGNORE = 3;

`ifdef NOV2PH_SEQ_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [7:0] half_per;
    logic [9:0] n_per;
    logic       phclk, int_rst, busy, done;
    logic [9:0] per_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    nov2ph_seq #(
        .HALF_W(8), .N_W(10), .RST_CYC(RST_C), .SETTLE_CYC(SET_C)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .half_per(half_per), .n_per(n_per),
        .phclk(phclk), .int_rst(int_rst), .busy(busy), .done(done),
        .per_cnt(per_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_phclk"}, int'(phclk), 0);
        check({tag, "_int_rst"}, int'(int_rst), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_per_cnt"}, int'(per_cnt), 0);
    endtask

    // Cycle k is the interval after edge k-1; start is sampled at edge 0.
    task automatic burst(input string name, input int h, input int n,
                         input int kind, input int ev, input int len);
        int he, run_end, done_c, last, e_ph, e_ir, e_busy, e_done, e_per;
        string t;
        he      = (h == 0) ? 1 : h;
        run_end = RST_C + 2 * he * n;
        if (kind == EV_ABORT && ABORT_EN && ev >= 1 && ev <= run_end) run_end = ev;
        done_c = run_end + SET_C + 1;

        @(negedge clk);
        half_per = 8'(h);
        n_per    = 10'(n);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= len; k++) begin
            if (k > 1) @(negedge clk);
            if (kind == EV_RST && k > ev) begin
                e_ph = 0; e_ir = 0; e_busy = 0; e_done = 0; e_per = 0;
            end else begin
                e_ir   = (k <= RST_C && k <= run_end) ? 1 : 0;
                e_ph   = (k > RST_C && k <= run_end && ((k - RST_C - 1) % (2 * he)) < he) ? 1 : 0;
                e_busy = (k <= run_end + SET_C) ? 1 : 0;
                e_done = (k == done_c) ? 1 : 0;
                last   = (k - 1 < run_end) ? k - 1 : run_end;
                e_per  = (last <= RST_C) ? 0 : (last - RST_C) / (2 * he);
            end
            t = $sformatf("%s_c%0d", name, k);
            check({t, "_phclk"}, int'(phclk), e_ph);
            check({t, "_int_rst"}, int'(int_rst), e_ir);
            check({t, "_busy"}, int'(busy), e_busy);
            check({t, "_done"}, int'(done), e_done);
            check({t, "_per_cnt"}, int'(per_cnt), e_per);

            start = 1'b0;
            abort = 1'b0;
            rst   = 1'b0;
            case (kind)
                EV_RST:   rst = (k == ev);
                EV_ABORT: abort = (k == ev);
                EV_IGNORE: begin
                    if (k == ev) begin
                        start    = 1'b1;
                        half_per = 8'd7;
                        n_per    = 10'd5;
                    end
                    if (k == done_c) start = 1'b1;
                end
                default: ;
            endcase
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b1;
        abort    = 1'b0;
        half_per = 8'd3;
        n_per    = 10'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle($sformatf("reset_c%0d", i));
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        burst("after_rst", 1, 0, EV_NONE, 0, 9);
        burst("nominal", 3, 2, EV_NONE, 0, 22);
        burst("n_zero", 5, 0, EV_NONE, 0, 10);
        burst("h_zero", 0, 1, EV_NONE, 0, 12);
        burst("h_zero_n3", 0, 3, EV_NONE, 0, 16);
        burst("ignored", 3, 2, EV_IGNORE, 6, 25);
        burst("rst_mid", 3, 2, EV_RST, 6, 25);
        burst("nominal2", 3, 2, EV_NONE, 0, 22);
        burst("abort_run", 3, 2, EV_ABORT, 12, 22);
        burst("abort_rs", 2, 1, EV_ABORT, 2, 14);
        burst("abort_idle", 1, 1, EV_ABORT, 9, 12);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
